// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory read port and
// the decode-side valid/ready port.
interface ifetch_if;
   logic        redirect;
   logic [15:0] redirect_addr;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        ir_valid;
   logic [15:0] ir_data;
   logic [15:0] ir_pc;
   logic        ir_ready;
   logic        busy;

   modport master (
      input  redirect, redirect_addr, mem_ack, mem_data, ir_ready,
      output mem_req, mem_addr, ir_valid, ir_data, ir_pc, busy
   );

   modport slave (
      output redirect, redirect_addr, mem_ack, mem_data, ir_ready,
      input  mem_req, mem_addr, ir_valid, ir_data, ir_pc, busy
   );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: issues req/ack reads at the fetch address, buffers
// {pc, instruction} pairs in a small prefetch FIFO and presents the head to decode.
module ifetch #(
   parameter int DEPTH = 2
) (
   input logic      clk,
   input logic      rst,
   ifetch_if.master bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;

   logic [1:0]    state_r, state_s;
   logic [15:0]   fetch_addr_r, fetch_addr_s;
   logic          mem_req_r, mem_req_s;
   logic [15:0]   mem_addr_r, mem_addr_s;
   logic [CW-1:0] count_r, count_s;
   logic [PW-1:0] wr_ptr_r, wr_ptr_s;
   logic [PW-1:0] rd_ptr_r, rd_ptr_s;
   logic [15:0]   fifo_pc_r   [DEPTH];
   logic [15:0]   fifo_data_r [DEPTH];
   logic          ir_valid_r, ir_valid_s;
   logic [15:0]   ir_data_r, ir_data_s;
   logic [15:0]   ir_pc_r, ir_pc_s;
   logic          push_s;
   logic          pop_s;
   logic [15:0]   redirect_even_s;

   assign redirect_even_s = {bus.redirect_addr[15:1], 1'b0};

   // Fetch FSM: a raised request is never withdrawn, so a redirect while waiting parks in DISCARD.
   always_comb begin
      state_s      = state_r;
      fetch_addr_s = fetch_addr_r;
      mem_req_s    = mem_req_r;
      mem_addr_s   = mem_addr_r;
      push_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.redirect) begin
               fetch_addr_s = redirect_even_s;
            end else if (count_r < DEPTH_C) begin
               state_s    = REQ;
               mem_req_s  = 1'b1;
               mem_addr_s = fetch_addr_r;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (bus.redirect) begin
               fetch_addr_s = redirect_even_s;
               if (bus.mem_ack) begin
                  state_s   = IDLE;
                  mem_req_s = 1'b0;
               end else begin
                  state_s = DISCARD;
               end
            end else if (bus.mem_ack) begin
               push_s       = 1'b1;
               fetch_addr_s = fetch_addr_r + 16'd2;
               state_s      = IDLE;
               mem_req_s    = 1'b0;
            end else begin
               state_s = REQ;
            end
         end
         DISCARD: begin
            if (bus.redirect) begin
               fetch_addr_s = redirect_even_s;
            end else begin
               fetch_addr_s = fetch_addr_r;
            end
            if (bus.mem_ack) begin
               state_s   = IDLE;
               mem_req_s = 1'b0;
            end else begin
               state_s = DISCARD;
            end
         end
         default: begin
            state_s   = IDLE;
            mem_req_s = 1'b0;
         end
      endcase
   end

   // FIFO bookkeeping and next head; the head is precomputed so decode sees registers only.
   always_comb begin
      pop_s = ir_valid_r & bus.ir_ready & ~bus.redirect;
      if (bus.redirect) begin
         count_s  = {CW{1'b0}};
         wr_ptr_s = {PW{1'b0}};
         rd_ptr_s = {PW{1'b0}};
      end else begin
         count_s  = count_r + CW'(push_s) - CW'(pop_s);
         wr_ptr_s = wr_ptr_r + PW'(push_s);
         rd_ptr_s = rd_ptr_r + PW'(pop_s);
      end
      ir_valid_s = (count_s != {CW{1'b0}});
      if (push_s && (wr_ptr_r == rd_ptr_s)) begin
         ir_pc_s   = fetch_addr_r;
         ir_data_s = bus.mem_data;
      end else begin
         ir_pc_s   = fifo_pc_r[rd_ptr_s];
         ir_data_s = fifo_data_r[rd_ptr_s];
      end
   end

   // State, FIFO storage and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         fetch_addr_r <= 16'h0000;
         mem_req_r    <= 1'b0;
         mem_addr_r   <= 16'h0000;
         count_r      <= {CW{1'b0}};
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         ir_valid_r   <= 1'b0;
         ir_data_r    <= 16'h0000;
         ir_pc_r      <= 16'h0000;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_r[i]   <= 16'h0000;
            fifo_data_r[i] <= 16'h0000;
         end
      end else begin
         state_r      <= state_s;
         fetch_addr_r <= fetch_addr_s;
         mem_req_r    <= mem_req_s;
         mem_addr_r   <= mem_addr_s;
         count_r      <= count_s;
         wr_ptr_r     <= wr_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         ir_valid_r   <= ir_valid_s;
         ir_data_r    <= ir_data_s;
         ir_pc_r      <= ir_pc_s;
         if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= fetch_addr_r;
            fifo_data_r[wr_ptr_r] <= bus.mem_data;
         end else begin
            fifo_pc_r[wr_ptr_r]   <= fifo_pc_r[wr_ptr_r];
            fifo_data_r[wr_ptr_r] <= fifo_data_r[wr_ptr_r];
         end
      end
   end

   assign bus.mem_req  = mem_req_r;
   assign bus.mem_addr = mem_addr_r;
   assign bus.busy     = mem_req_r;
   assign bus.ir_valid = ir_valid_r;
   assign bus.ir_data  = ir_data_r;
   assign bus.ir_pc    = ir_pc_r;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a cycle-stepped memory responder plus pop monitor,
// with hand-computed expected addresses, pcs and instruction words.
module tb_ifetch;

   logic clk;
   logic rst;
   ifetch_if bus ();

   ifetch #(.DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_errors;
   int          lat;
   int          wcnt;
   int          dead_seen;
   bit          redir_on_ack;
   logic [15:0] roa_addr;
   logic [15:0] img0;
   logic [15:0] addr_log [$];
   logic [15:0] pop_pc   [$];
   logic [15:0] pop_data [$];

   task automatic check16(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] img(input logic [15:0] a);
      case (a)
         16'h0000: img = img0;
         16'h0002: img = 16'h2222;
         16'h0004: img = 16'h3333;
         16'h0006: img = 16'hDEAD;
         default:  img = a ^ 16'hC000;
      endcase
   endfunction

   // One clock: respond to memory, log pops, then advance to the next falling edge.
   task automatic cyc();
      if (bus.mem_ack) begin
         bus.mem_ack = 1'b0;
         wcnt = 0;
      end else if (bus.mem_req) begin
         wcnt++;
         if (wcnt >= lat) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = img(bus.mem_addr);
            addr_log.push_back(bus.mem_addr);
            wcnt = 0;
            if (redir_on_ack) begin
               bus.redirect      = 1'b1;
               bus.redirect_addr = roa_addr;
            end
         end
      end else begin
         wcnt = 0;
      end
      if (bus.ir_valid && bus.ir_ready && !bus.redirect) begin
         pop_pc.push_back(bus.ir_pc);
         pop_data.push_back(bus.ir_data);
         if (bus.ir_data == 16'hDEAD) dead_seen++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.redirect = 1'b0;
   endtask

   task automatic do_reset();
      rst               = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = 16'h0000;
      bus.mem_ack       = 1'b0;
      bus.mem_data      = 16'h0000;
      bus.ir_ready      = 1'b0;
      wcnt              = 0;
      lat               = 1;
      redir_on_ack      = 1'b0;
      img0              = 16'h1111;
      addr_log.delete();
      pop_pc.delete();
      pop_data.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      dead_seen = 0;

      // Reset values, then straight-line fetch with ir_ready=1.
      rst = 1'b0;
      bus.redirect = 1'b0; bus.redirect_addr = 16'h0000;
      bus.mem_ack = 1'b0; bus.mem_data = 16'h0000; bus.ir_ready = 1'b0;
      repeat (2) @(negedge clk);
      check16("rst_mem_req",  16'(bus.mem_req),  16'd0);
      check16("rst_mem_addr", bus.mem_addr,      16'h0000);
      check16("rst_ir_valid", 16'(bus.ir_valid), 16'd0);
      check16("rst_ir_data",  bus.ir_data,       16'h0000);
      check16("rst_ir_pc",    bus.ir_pc,         16'h0000);
      check16("rst_busy",     16'(bus.busy),     16'd0);

      do_reset();
      bus.ir_ready = 1'b1;
      for (int i = 0; i < 40 && pop_pc.size() < 3; i++) cyc();
      check16("t1_pops", 16'(pop_pc.size()), 16'd3);
      if (pop_pc.size() >= 3 && addr_log.size() >= 3) begin
         check16("t1_addr0", addr_log[0], 16'h0000);
         check16("t1_addr1", addr_log[1], 16'h0002);
         check16("t1_addr2", addr_log[2], 16'h0004);
         check16("t1_pc0",   pop_pc[0],   16'h0000);
         check16("t1_dat0",  pop_data[0], 16'h1111);
         check16("t1_pc1",   pop_pc[1],   16'h0002);
         check16("t1_dat1",  pop_data[1], 16'h2222);
         check16("t1_pc2",   pop_pc[2],   16'h0004);
         check16("t1_dat2",  pop_data[2], 16'h3333);
      end

      // Backpressure: FIFO fills after two pushes, one pop restarts fetching.
      do_reset();
      repeat (8) cyc();
      check16("t2_nreq",     16'(addr_log.size()), 16'd2);
      check16("t2_req_full", 16'(bus.mem_req),     16'd0);
      check16("t2_valid",    16'(bus.ir_valid),    16'd1);
      check16("t2_head_pc",  bus.ir_pc,            16'h0000);
      check16("t2_head_dat", bus.ir_data,          16'h1111);
      bus.ir_ready = 1'b1;
      cyc();
      bus.ir_ready = 1'b0;
      check16("t2_popped",   16'(pop_pc.size()),   16'd1);
      check16("t2_req_pop",  16'(bus.mem_req),     16'd0);
      check16("t2_head2_pc", bus.ir_pc,            16'h0002);
      check16("t2_head2_dt", bus.ir_data,          16'h2222);
      cyc();
      check16("t2_req_res",  16'(bus.mem_req),     16'd1);
      check16("t2_addr_res", bus.mem_addr,         16'h0004);
      check16("t2_busy",     16'(bus.busy),        16'd1);

      // Redirect while a request is outstanding: stale word discarded.
      bus.ir_ready = 1'b1;
      for (int i = 0; i < 20 && !(bus.mem_req && bus.mem_addr == 16'h0006); i++) cyc();
      check16("t3_req6", bus.mem_addr, 16'h0006);
      lat = 3;
      bus.redirect = 1'b1;
      bus.redirect_addr = 16'h0101;
      cyc();
      check16("t3_req_held",  16'(bus.mem_req),  16'd1);
      check16("t3_addr_held", bus.mem_addr,      16'h0006);
      check16("t3_flushed",   16'(bus.ir_valid), 16'd0);
      cyc();
      check16("t3_addr_held2", bus.mem_addr, 16'h0006);
      cyc();
      check16("t3_req_drop", 16'(bus.mem_req),  16'd0);
      check16("t3_no_dead",  16'(bus.ir_valid), 16'd0);
      lat = 1;
      pop_pc.delete();
      pop_data.delete();
      cyc();
      check16("t3_new_req",  16'(bus.mem_req), 16'd1);
      check16("t3_new_addr", bus.mem_addr,     16'h0100);
      for (int i = 0; i < 10 && pop_pc.size() < 1; i++) cyc();
      check16("t3_npop", 16'(pop_pc.size()), 16'd1);
      if (pop_pc.size() >= 1) begin
         check16("t3_first_pc",  pop_pc[0],   16'h0100);
         check16("t3_first_dat", pop_data[0], 16'hC100);
      end
      check16("t3_dead_seen", 16'(dead_seen), 16'd0);

      // Redirect in the same cycle as the ack.
      do_reset();
      img0 = 16'hBEEF;
      redir_on_ack = 1'b1;
      roa_addr = 16'h0200;
      cyc();
      cyc();
      redir_on_ack = 1'b0;
      check16("t4_acked0",  16'(addr_log.size()), 16'd1);
      check16("t4_valid",   16'(bus.ir_valid),    16'd0);
      check16("t4_req_low", 16'(bus.mem_req),     16'd0);
      cyc();
      check16("t4_req",  16'(bus.mem_req), 16'd1);
      check16("t4_addr", bus.mem_addr,     16'h0200);
      cyc();
      check16("t4_hvalid", 16'(bus.ir_valid), 16'd1);
      check16("t4_hpc",    bus.ir_pc,         16'h0200);
      check16("t4_hdat",   bus.ir_data,       16'hC200);

      // Address wrap from 0xFFFE to 0x0000.
      do_reset();
      bus.ir_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_addr = 16'hFFFE;
      cyc();
      check16("t5_idle", 16'(bus.mem_req), 16'd0);
      for (int i = 0; i < 20 && pop_pc.size() < 2; i++) cyc();
      check16("t5_npop", 16'(pop_pc.size()), 16'd2);
      if (pop_pc.size() >= 2) begin
         check16("t5_pc0",  pop_pc[0],   16'hFFFE);
         check16("t5_dat0", pop_data[0], 16'h3FFE);
         check16("t5_pc1",  pop_pc[1],   16'h0000);
         check16("t5_dat1", pop_data[1], 16'h1111);
      end

      // Asynchronous reset mid-request with one word buffered.
      do_reset();
      for (int i = 0; i < 10 && !bus.ir_valid; i++) cyc();
      check16("t6_buffered", 16'(bus.ir_valid), 16'd1);
      lat = 100;
      for (int i = 0; i < 10 && !bus.mem_req; i++) cyc();
      check16("t6_req_out", 16'(bus.mem_req), 16'd1);
      #2;
      rst = 1'b0;
      #1;
      check16("t6_req_drop",   16'(bus.mem_req),  16'd0);
      check16("t6_valid_drop", 16'(bus.ir_valid), 16'd0);
      check16("t6_busy_drop",  16'(bus.busy),     16'd0);
      check16("t6_addr_rst",   bus.mem_addr,      16'h0000);
      @(negedge clk);
      rst = 1'b1;
      wcnt = 0;
      lat = 1;
      for (int i = 0; i < 10 && !bus.mem_req; i++) cyc();
      check16("t6_req_again", 16'(bus.mem_req), 16'd1);
      check16("t6_addr_zero", bus.mem_addr,     16'h0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
